// File: rtl/two_s_complement_neg_core.sv
// neg_core: combinational two's-complement negation core.
//   a          : operand
//   y          : (~a + 1) mod 2^WIDTH
//   is_min_neg : a is 1 followed by WIDTH-1 zeros (negation not representable)
//   is_zero    : a is all zeros
module two_s_complement_neg_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y,
    output logic             is_min_neg,
    output logic             is_zero
);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] inv;
    logic [WIDTH-1:0] c;     // carry into each half-adder cell

    assign inv  = ~a;
    assign c[0] = 1'b1;      // +1 enters as carry-in of bit 0

    // Ripple of half-adder cells; carry out of the MSB is dropped, so no cell
    // drives a c[WIDTH].
    for (genvar i = 0; i < WIDTH; i++) begin : g_ha
        assign y[i] = inv[i] ^ c[i];
        if (i < WIDTH-1) begin : g_carry
            assign c[i+1] = inv[i] & c[i];
        end
    end

    assign is_min_neg = (a == MIN_NEG);
    assign is_zero    = (a == '0);
endmodule

// File: rtl/two_s_complement.sv
// two_s_complement: registered two's-complement negator, 1-cycle latency,
// full throughput, no backpressure.
//   clk, rst  : rising-edge clock, async active-high reset
//   In        : operand (accepted when in_valid)
//   Out       : registered negation of last accepted In
//   out_valid : Out/flags were produced from In one cycle earlier
//   overflow  : last accepted In was the most-negative value
//   zero      : last accepted In was zero
module two_s_complement #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] In,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Out,
    output logic             out_valid,
    output logic             overflow,
    output logic             zero
);
    logic [WIDTH-1:0] neg_y;
    logic             neg_min, neg_zero;
    logic             vld_pipe;

    two_s_complement_neg_core #(.WIDTH(WIDTH)) u_core (
        .a          (In),
        .y          (neg_y),
        .is_min_neg (neg_min),
        .is_zero    (neg_zero)
    );

    // Data/flags only load on accepted operands; otherwise they hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Out      <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            vld_pipe <= 1'b0;
        end else begin
            vld_pipe <= in_valid;
            if (in_valid) begin
                Out      <= neg_y;
                overflow <= neg_min;
                zero     <= neg_zero;
            end
        end
    end

    assign out_valid = vld_pipe;
endmodule

// File: tb/tb_two_s_complement.sv
module tb_two_s_complement;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in4;
    logic       vld4;
    logic [3:0] out4;
    logic       ov4, vo4, z4;
    logic [7:0] in8;
    logic       vld8;
    logic [7:0] out8;
    logic       ov8, vo8, z8;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    two_s_complement #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .In(in4), .in_valid(vld4),
        .Out(out4), .out_valid(vo4), .overflow(ov4), .zero(z4)
    );

    two_s_complement #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .In(in8), .in_valid(vld8),
        .Out(out8), .out_valid(vo8), .overflow(ov8), .zero(z8)
    );

    // Reference: negation as 2^W - x reduced mod 2^W.
    function automatic logic [3:0] neg4(input int x);
        int r;
        r = (16 - x) % 16;
        return r[3:0];
    endfunction

    function automatic logic [7:0] neg8(input int x);
        int r;
        r = (256 - x) % 256;
        return r[7:0];
    endfunction

    // {out_valid, overflow, zero, Out}
    function automatic logic [6:0] exp4(input logic v, input int x);
        return {v, x == 8, x == 0, neg4(x)};
    endfunction

    task automatic test_reset();
        logic [6:0] e;
        // Reset asserted from time 0.
        #1;
        e = 7'b0;
        total++;
        if ({vo4, ov4, z4, out4} !== e)
            $display("FAIL reset_init: got %b expected %b", {vo4, ov4, z4, out4}, e);
        else pass_cnt++;
        @(negedge clk); rst = 1'b0; in4 = 4'd3; vld4 = 1'b1;
        @(posedge clk); #1;
        e = exp4(1'b1, 3);
        total++;
        if ({vo4, ov4, z4, out4} !== e)
            $display("FAIL reset_preload: got %b expected %b", {vo4, ov4, z4, out4}, e);
        else pass_cnt++;
        // Assert between edges: must clear without a clock edge.
        #1 rst = 1'b1; #1;
        e = 7'b0;
        total++;
        if ({vo4, ov4, z4, out4} !== e)
            $display("FAIL reset_async: got %b expected %b", {vo4, ov4, z4, out4}, e);
        else pass_cnt++;
        @(posedge clk); #1;
        total++;
        if ({vo4, ov4, z4, out4} !== e)
            $display("FAIL reset_hold: got %b expected %b", {vo4, ov4, z4, out4}, e);
        else pass_cnt++;
        @(negedge clk); rst = 1'b0; vld4 = 1'b0;
    endtask

    task automatic test_sweep();
        logic [6:0] e;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); in4 = 4'(i); vld4 = 1'b1;
            @(posedge clk); #1;
            e = exp4(1'b1, i);
            total++;
            if ({vo4, ov4, z4, out4} !== e)
                $display("FAIL sweep_in%0d: got %b expected %b", i, {vo4, ov4, z4, out4}, e);
            else pass_cnt++;
        end
        // Spot values straight from the arithmetic definition.
        @(negedge clk); in4 = 4'b0111;
        @(posedge clk); #1;
        total++;
        if (out4 !== 4'b1001) $display("FAIL sweep_0111: got %b expected 1001", out4);
        else pass_cnt++;
        @(negedge clk); in4 = 4'b1000;
        @(posedge clk); #1;
        total++;
        if ({ov4, out4} !== 5'b1_1000) $display("FAIL sweep_1000: got %b expected 11000", {ov4, out4});
        else pass_cnt++;
        @(negedge clk); vld4 = 1'b0;
    endtask

    task automatic test_hold();
        @(negedge clk); in4 = 4'b0011; vld4 = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({vo4, out4} !== 5'b1_1101) $display("FAIL hold_load: got %b expected 11101", {vo4, out4});
        else pass_cnt++;
        @(negedge clk); in4 = 4'b0101; vld4 = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({vo4, ov4, z4, out4} !== 7'b000_1101)
            $display("FAIL hold_keep: got %b expected 0001101", {vo4, ov4, z4, out4});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] ins  [3] = '{4'b0001, 4'b0100, 4'b1100};
        logic [3:0] outs [3] = '{4'b1111, 4'b1100, 4'b0100};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); in4 = ins[i]; vld4 = 1'b1;
            @(posedge clk); #1;
            total++;
            if ({vo4, out4} !== {1'b1, outs[i]})
                $display("FAIL b2b_%0d: got %b expected %b", i, {vo4, out4}, {1'b1, outs[i]});
            else pass_cnt++;
        end
        @(negedge clk); vld4 = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk); in4 = 4'b0110; vld4 = 1'b1;
        #2 rst = 1'b1; #1;
        @(posedge clk); #1;
        total++;
        if ({vo4, ov4, z4, out4} !== 7'b0)
            $display("FAIL rstmid_edge: got %b expected 0000000", {vo4, ov4, z4, out4});
        else pass_cnt++;
        @(negedge clk); rst = 1'b0; vld4 = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({vo4, out4} !== 5'b0)
            $display("FAIL rstmid_after: got %b expected 00000", {vo4, out4});
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [6:0] m;   // model state {out_valid, overflow, zero, Out}
        int x;
        logic v;
        m = {1'b0, ov4, z4, out4};
        for (int i = 0; i < 60; i++) begin
            x = int'($urandom_range(0, 15));
            v = ($urandom_range(0, 3) != 0);
            @(negedge clk); in4 = 4'(x); vld4 = v;
            @(posedge clk); #1;
            if (v) m = exp4(1'b1, x);
            else   m[6] = 1'b0;
            total++;
            if ({vo4, ov4, z4, out4} !== m)
                $display("FAIL random_%0d in=%0d v=%b: got %b expected %b", i, x, v, {vo4, ov4, z4, out4}, m);
            else pass_cnt++;
        end
        @(negedge clk); vld4 = 1'b0;
    endtask

    task automatic test_width8();
        logic [7:0] ins  [3] = '{8'h80, 8'h01, 8'h7F};
        logic [9:0] exps [3] = '{{1'b1, 1'b1, 8'h80}, {1'b1, 1'b0, 8'hFF}, {1'b1, 1'b0, 8'h81}};
        int x;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); in8 = ins[i]; vld8 = 1'b1;
            @(posedge clk); #1;
            total++;
            if ({vo8, ov8, out8} !== exps[i])
                $display("FAIL w8_vec%0d: got %h expected %h", i, {vo8, ov8, out8}, exps[i]);
            else pass_cnt++;
        end
        for (int i = 0; i < 20; i++) begin
            x = int'($urandom_range(0, 255));
            @(negedge clk); in8 = 8'(x);
            @(posedge clk); #1;
            total++;
            if ({vo8, ov8, z8, out8} !== {1'b1, x == 128, x == 0, neg8(x)})
                $display("FAIL w8_rand in=%0d: got %h expected %h", x, {vo8, ov8, z8, out8},
                         {1'b1, x == 128, x == 0, neg8(x)});
            else pass_cnt++;
        end
        @(negedge clk); vld8 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in4 = '0; vld4 = 1'b0; in8 = '0; vld8 = 1'b0;
        test_reset();
        test_sweep();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_width8();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got no finish expected finish");
        $fatal(1);
    end
endmodule
